alu_cmd_issuer: RTL and testbench
=================================

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter DIV_OP, default 4'h3: ALU opcode of the multi-cycle divide, completed by alu_done.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT_DIV, used only when ALU_ISSUER_TIMEOUT_EN is defined.
REQ-003 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock shared with the ALU.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 cmd_op  in  4; cmd_a  in  32; cmd_b  in  32; cmd_inv  in  1; cmd_inc  in  1  command fields.
REQ-009 alu_aluop  out  4; alu_a  out  32; alu_b  out  32; alu_output_inverted  out  1; alu_output_inc  out  1  ALU operand drive.
REQ-010 alu_done  in  1; alu_res_high  in  32; alu_res_low  in  32  ALU completion and registered result.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_high  out  32; rsp_low  out  32; rsp_op  out  4; rsp_err  out  1  response channel.
REQ-012 busy  out  1  high in any state other than IDLE; op_count  out  16  completed-response counter.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, WAIT_DIV, CAPTURE and RESP; cmd_ready is 1 only in IDLE.
REQ-014 IDLE: on cmd_valid&cmd_ready, the block SHALL register all cmd_* fields onto the alu_* outputs and go to EXEC.
REQ-015 EXEC (1 cycle): if alu_aluop==DIV_OP go to WAIT_DIV, else go to CAPTURE.
REQ-016 WAIT_DIV: stay until alu_done==1, then go to CAPTURE.
REQ-017 CAPTURE (1 cycle): the block SHALL latch alu_res_high/low into rsp_high/low and alu_aluop into rsp_op, set rsp_valid, and go to RESP.
REQ-018 Latency: for non-divide ops, rsp_valid SHALL be high 3 edges after the accepting edge (EXEC, CAPTURE, RESP); for divide ops, 2 edges after the first edge sampling alu_done=1.
REQ-019 RESP: rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0; on rsp_ready=1, clear rsp_valid, increment op_count, and go to IDLE.
REQ-020 alu_* outputs SHALL hold their last issued values in all states, including IDLE.
REQ-021 op_count SHALL wrap from 16'hFFFF to 0.
REQ-022 cmd_valid outside IDLE SHALL be ignored; no command is queued.
REQ-023 alu_done high outside WAIT_DIV SHALL be ignored.
REQ-024 Opcodes 4'hD-4'hF SHALL be issued as non-divide ops; the response carries whatever the ALU returns.
REQ-025 rsp_err SHALL be 0 on every response unless it is set by REQ-030.

Reset
REQ-026 On rst=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0 (cmd_ready becomes 1 as a function of IDLE); any in-flight command SHALL be discarded.
REQ-027 rst SHALL take priority over every handshake sampled at the same edge.

Configuration
REQ-028 The macro ALU_ISSUER_TIMEOUT_EN SHALL control the divide timeout.
REQ-029 Without the macro: WAIT_DIV waits indefinitely, and rsp_err is constant 0.
REQ-030 With the macro: an 8-bit cycle counter, cleared on WAIT_DIV entry, counts cycles in WAIT_DIV. When it reaches TIMEOUT with alu_done=0, the FSM goes to CAPTURE with rsp_err=1, and rsp_high/low are forced to 0.
REQ-031 With the macro: alu_done=1 in the same cycle the count reaches TIMEOUT SHALL be treated as a normal completion, with rsp_err=0.

Verification
REQ-032 Add: op=0, a=5, b=7, inv=0, inc=0 -> rsp_valid high 3 edges after accept; rsp_low=12, rsp_high=0, rsp_op=0.
REQ-033 Carry: op=0, a=32'hFFFFFFFF, b=1 -> rsp_low=0, rsp_high=1.
REQ-034 Divide: op=3, a=100, b=7, alu_done pulsed after 34 cycles -> rsp_low=14, rsp_high=2, rsp_err=0.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0; on release, op_count increments by 1 and cmd_ready=1 on the next cycle.
REQ-036 Reset mid-WAIT_DIV: rst=1 for one edge -> next cycle IDLE, rsp_valid=0, op_count=0, and a later alu_done pulse produces no response.
REQ-037 Timeout (macro defined): op=3 with alu_done held 0 -> after 64 cycles in WAIT_DIV, the response has rsp_err=1 and rsp_high=rsp_low=0; without the macro, busy stays 1.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command issuer for a multi-cycle ALU: accepts one command, drives the ALU, returns one response.
// Optional divide timeout is enabled by defining ALU_ISSUER_TIMEOUT_EN.
module alu_cmd_issuer #(
   parameter logic [3:0]  DIV_OP  = 4'h3,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic        cmd_inv,
   input  logic        cmd_inc,
   output logic [3:0]  alu_aluop,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_output_inverted,
   output logic        alu_output_inc,
   input  logic        alu_done,
   input  logic [31:0] alu_res_high,
   input  logic [31:0] alu_res_low,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_high,
   output logic [31:0] rsp_low,
   output logic [3:0]  rsp_op,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [2:0] {IDLE, EXEC, WAIT_DIV, CAPTURE, RESP} state_e;

   // The wait counter is 8 bits wide, so the limit must be reachable.
   if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..255");
   end

   state_e      state_q, state_d;
   logic [3:0]  aluop_q, aluop_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        inv_q, inv_d;
   logic        inc_q, inc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_high_q, rsp_high_d;
   logic [31:0] rsp_low_q, rsp_low_d;
   logic [3:0]  rsp_op_q, rsp_op_d;
   logic [15:0] op_count_q, op_count_d;
   logic        cmd_ready_q;
   logic        busy_q;
`ifdef ALU_ISSUER_TIMEOUT_EN
   logic [7:0]  tmo_q, tmo_d;
   logic        tmo_err_q, tmo_err_d;
   logic        rsp_err_q, rsp_err_d;
`endif

   // Next-state and datapath decode
   always_comb begin
      state_d     = state_q;
      aluop_d     = aluop_q;
      a_d         = a_q;
      b_d         = b_q;
      inv_d       = inv_q;
      inc_d       = inc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_high_d  = rsp_high_q;
      rsp_low_d   = rsp_low_q;
      rsp_op_d    = rsp_op_q;
      op_count_d  = op_count_q;
`ifdef ALU_ISSUER_TIMEOUT_EN
      tmo_d       = tmo_q;
      tmo_err_d   = tmo_err_q;
      rsp_err_d   = rsp_err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               aluop_d = cmd_op;
               a_d     = cmd_a;
               b_d     = cmd_b;
               inv_d   = cmd_inv;
               inc_d   = cmd_inc;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = (aluop_q == DIV_OP) ? WAIT_DIV : CAPTURE;
`ifdef ALU_ISSUER_TIMEOUT_EN
            tmo_d     = 8'd0;
            tmo_err_d = 1'b0;
`endif
         end
         WAIT_DIV: begin
            if (alu_done) begin
               state_d = CAPTURE;
            end
`ifdef ALU_ISSUER_TIMEOUT_EN
            else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_q + 8'd1 == 8'(TIMEOUT)) begin
                  tmo_err_d = 1'b1;
                  state_d   = CAPTURE;
               end
            end
`endif
         end
         CAPTURE: begin
            rsp_high_d  = alu_res_high;
            rsp_low_d   = alu_res_low;
            rsp_op_d    = aluop_q;
            rsp_valid_d = 1'b1;
`ifdef ALU_ISSUER_TIMEOUT_EN
            rsp_err_d = tmo_err_q;
            if (tmo_err_q) begin
               rsp_high_d = 32'd0;
               rsp_low_d  = 32'd0;
            end
`endif
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registers; reset wins over any handshake at the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         aluop_q     <= 4'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         inv_q       <= 1'b0;
         inc_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_high_q  <= 32'd0;
         rsp_low_q   <= 32'd0;
         rsp_op_q    <= 4'd0;
         op_count_q  <= 16'd0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
         tmo_q       <= 8'd0;
         tmo_err_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         aluop_q     <= aluop_d;
         a_q         <= a_d;
         b_q         <= b_d;
         inv_q       <= inv_d;
         inc_q       <= inc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_high_q  <= rsp_high_d;
         rsp_low_q   <= rsp_low_d;
         rsp_op_q    <= rsp_op_d;
         op_count_q  <= op_count_d;
         cmd_ready_q <= (state_d == IDLE);
         busy_q      <= (state_d != IDLE);
`ifdef ALU_ISSUER_TIMEOUT_EN
         tmo_q       <= tmo_d;
         tmo_err_q   <= tmo_err_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign cmd_ready           = cmd_ready_q;
   assign busy                = busy_q;
   assign alu_aluop           = aluop_q;
   assign alu_a               = a_q;
   assign alu_b               = b_q;
   assign alu_output_inverted = inv_q;
   assign alu_output_inc      = inc_q;
   assign rsp_valid           = rsp_valid_q;
   assign rsp_high            = rsp_high_q;
   assign rsp_low             = rsp_low_q;
   assign rsp_op              = rsp_op_q;
   assign op_count            = op_count_q;
`ifdef ALU_ISSUER_TIMEOUT_EN
   assign rsp_err             = rsp_err_q;
`else
   assign rsp_err             = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU and a response scoreboard.
module tb_alu_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic        cmd_inv, cmd_inc;
   logic [3:0]  alu_aluop;
   logic [31:0] alu_a, alu_b;
   logic        alu_output_inverted, alu_output_inc;
   logic        alu_done;
   logic [31:0] alu_res_high, alu_res_low;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_high, rsp_low;
   logic [3:0]  rsp_op;
   logic        rsp_err;
   logic        busy;
   logic [15:0] op_count;

   typedef struct packed {
      logic [31:0] high;
      logic [31:0] low;
      logic [3:0]  op;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_cmd_issuer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_inv(cmd_inv), .cmd_inc(cmd_inc),
      .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b),
      .alu_output_inverted(alu_output_inverted), .alu_output_inc(alu_output_inc),
      .alu_done(alu_done), .alu_res_high(alu_res_high), .alu_res_low(alu_res_low),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_high(rsp_high), .rsp_low(rsp_low),
      .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   // Behavioural ALU: op0 add with carry in high, op3 divide (quotient low, remainder high), else xor
   function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic inv, input logic inc);
      logic [31:0] hi, lo;
      logic [32:0] s;
      s = 33'd0;
      case (op)
         4'h0: begin s = {1'b0, a} + {1'b0, b}; hi = {31'd0, s[32]}; lo = s[31:0]; end
         4'h3: begin
            hi = (b == 32'd0) ? a : a % b;
            lo = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         end
         default: begin hi = 32'd0; lo = a ^ b; end
      endcase
      if (inv) lo = ~lo;
      if (inc) lo = lo + 32'd1;
      return {hi, lo};
   endfunction

   always_comb begin
      logic [63:0] r;
      r = alu_fn(alu_aluop, alu_a, alu_b, alu_output_inverted, alu_output_inc);
      alu_res_high = r[63:32];
      alu_res_low  = r[31:0];
   end

   function automatic exp_t mk(input logic [31:0] high, input logic [31:0] low, input logic [3:0] op, input logic err);
      exp_t e;
      e.high = high; e.low = low; e.op = op; e.err = err;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic inv, input logic inc);
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_inv = inv; cmd_inc = inc;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("accept_busy", 64'(busy), 64'd1);
      chk("accept_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("alu_aluop", 64'(alu_aluop), 64'(op));
      chk("alu_a", 64'(alu_a), 64'(a));
      chk("alu_b", 64'(alu_b), 64'(b));
   endtask

   // Steps until rsp_valid; edges counts clock edges including the reference edge already taken
   task automatic wait_valid(input int start, input int limit, output int edges);
      edges = start;
      while (!rsp_valid && edges < limit) begin
         step();
         edges++;
      end
      if (!rsp_valid) chk("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
   endtask

   task automatic check_rsp();
      exp_t e;
      chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("rsp_high", 64'(rsp_high), 64'(e.high));
         chk("rsp_low", 64'(rsp_low), 64'(e.low));
         chk("rsp_op", 64'(rsp_op), 64'(e.op));
         chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
   endtask

   task automatic release_rsp();
      logic [15:0] cnt;
      cnt = op_count;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("release_valid", 64'(rsp_valid), 64'd0);
      chk("op_count_inc", 64'(op_count), 64'(16'(cnt + 16'd1)));
      chk("release_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("release_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      logic [63:0] r;
      logic [63:0] snap;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
      cmd_inv = 1'b0; cmd_inc = 1'b0; alu_done = 1'b0; rsp_ready = 1'b0;
      step();
      step();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      rst = 1'b0;
      step();

      // Add 5+7
      sb_q.push_back(mk(32'd0, 32'd12, 4'h0, 1'b0));
      issue(4'h0, 32'd5, 32'd7, 1'b0, 1'b0);
      wait_valid(1, 20, e);
      chk("add_latency", 64'(e), 64'd3);
      check_rsp();
      release_rsp();
      chk("alu_hold_idle", 64'(alu_a), 64'd5);

      // Add with carry out
      sb_q.push_back(mk(32'd1, 32'd0, 4'h0, 1'b0));
      issue(4'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      wait_valid(1, 20, e);
      chk("carry_latency", 64'(e), 64'd3);
      check_rsp();
      release_rsp();

      // High opcode with invert and increment, treated as a non-divide op
      r = alu_fn(4'hD, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);
      sb_q.push_back(mk(r[63:32], r[31:0], 4'hD, 1'b0));
      issue(4'hD, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);
      chk("alu_inv", 64'(alu_output_inverted), 64'd1);
      chk("alu_inc", 64'(alu_output_inc), 64'd1);
      wait_valid(1, 20, e);
      chk("opD_latency", 64'(e), 64'd3);
      check_rsp();
      release_rsp();

      // Divide 100/7; an alu_done seen in EXEC must be ignored
      sb_q.push_back(mk(32'd2, 32'd14, 4'h3, 1'b0));
      issue(4'h3, 32'd100, 32'd7, 1'b0, 1'b0);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      for (int i = 0; i < 33; i++) step();
      chk("div_wait_valid", 64'(rsp_valid), 64'd0);
      chk("div_wait_busy", 64'(busy), 64'd1);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      wait_valid(1, 10, e);
      chk("div_latency", 64'(e), 64'd2);
      check_rsp();
      release_rsp();

      // Backpressure with a competing command held on cmd_valid
      sb_q.push_back(mk(32'd0, 32'd30, 4'h0, 1'b0));
      issue(4'h0, 32'd10, 32'd20, 1'b0, 1'b0);
      wait_valid(1, 20, e);
      snap = {rsp_high, rsp_low};
      cmd_op = 4'h1; cmd_a = 32'd99; cmd_b = 32'd1; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_stable", {rsp_high, rsp_low}, snap);
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      cmd_valid = 1'b0;
      check_rsp();
      release_rsp();
      step();
      chk("bp_no_queue", 64'(busy), 64'd0);
      chk("bp_alu_hold", 64'(alu_a), 64'd10);

      // Reset while waiting for a divide
      issue(4'h3, 32'd50, 32'd5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_op_count", 64'(op_count), 64'd0);
      chk("mid_rst_aluop", 64'(alu_aluop), 64'd0);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("late_done_no_rsp", 64'(rsp_valid), 64'd0);
      end

`ifdef ALU_ISSUER_TIMEOUT_EN
      // Timeout: 64 cycles in WAIT_DIV with no completion
      sb_q.push_back(mk(32'd0, 32'd0, 4'h3, 1'b1));
      issue(4'h3, 32'd9, 32'd4, 1'b0, 1'b0);
      wait_valid(1, 200, e);
      chk("tmo_latency", 64'(e), 64'd67);
      check_rsp();
      release_rsp();

      // Completion on the very cycle the limit is reached is a normal result
      sb_q.push_back(mk(32'd1, 32'd2, 4'h3, 1'b0));
      issue(4'h3, 32'd9, 32'd4, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) step();
      chk("tmo_edge_wait", 64'(rsp_valid), 64'd0);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      wait_valid(66, 80, e);
      chk("tmo_edge_latency", 64'(e), 64'd67);
      check_rsp();
      release_rsp();
`else
      // Without the timeout a divide waits indefinitely
      sb_q.push_back(mk(32'd1, 32'd2, 4'h3, 1'b0));
      issue(4'h3, 32'd9, 32'd4, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step();
      chk("no_tmo_busy", 64'(busy), 64'd1);
      chk("no_tmo_valid", 64'(rsp_valid), 64'd0);
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
      wait_valid(1, 10, e);
      chk("no_tmo_latency", 64'(e), 64'd2);
      check_rsp();
      release_rsp();
`endif
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
